// File: rtl/snake_pixel_engine.sv
// Snake game state and registered per-pixel query flags for the VGA renderer.
// Define SNAKE_WRAP_EN to remove the walls and wrap the head around the grid edges.
module snake_pixel_engine #(
  parameter int MAX_LEN  = 16,
  parameter int TICK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic       snake_on,
  output logic       cherry_on,
  output logic       boundary,
  output logic       game_over,
  output logic [7:0] score
);

  localparam int CW = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {IDLE, RUN, RELOC, OVER} state_t;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

  state_t          state, state_nxt;
  dir_t            dir, cur_dir, req_dir, ref_dir;
  logic [5:0]      seg_x [MAX_LEN];
  logic [4:0]      seg_y [MAX_LEN];
  logic [5:0]      len;
  logic [5:0]      cherry_x;
  logic [4:0]      cherry_y;
  logic [CW-1:0]   tick_cnt;
  logic [15:0]     lfsr;

  logic            tick, any_btn, req_ok;
  logic [5:0]      nx, cand_x, cx, cy;
  logic [4:0]      ny, cand_y;
  logic            wall_hit, self_hit, eat, grow, cand_ok;
  logic            in_range, snake_hit, cherry_hit, wall_px;
  logic [MAX_LEN-1:0] active;

  assign any_btn   = btn_up | btn_down | btn_left | btn_right;
  assign tick      = (state == RUN) && (tick_cnt == CW'(TICK_DIV - 1));
  // On the tick clk the pending direction becomes the applied one, so reversals are judged against it.
  assign ref_dir   = tick ? dir : cur_dir;
  assign game_over = (state == OVER);
  assign cand_x    = lfsr[5:0];
  assign cand_y    = lfsr[12:8];
  assign cx        = pixel_x[9:4];
  assign cy        = pixel_y[9:4];
  assign in_range  = (pixel_x < 10'd640) && (pixel_y < 10'd480);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    req_dir = RIGHT;
    if (btn_up)        req_dir = UP;
    else if (btn_down) req_dir = DOWN;
    else if (btn_left) req_dir = LEFT;
    req_ok = any_btn && (req_dir != dir_t'(ref_dir ^ 2'b01));
  end

  always_comb begin
    nx       = seg_x[0];
    ny       = seg_y[0];
    wall_hit = 1'b0;
`ifdef SNAKE_WRAP_EN
    case (dir)
      UP:      ny = (seg_y[0] == 5'd0)  ? 5'd29 : seg_y[0] - 5'd1;
      DOWN:    ny = (seg_y[0] == 5'd29) ? 5'd0  : seg_y[0] + 5'd1;
      LEFT:    nx = (seg_x[0] == 6'd0)  ? 6'd39 : seg_x[0] - 6'd1;
      default: nx = (seg_x[0] == 6'd39) ? 6'd0  : seg_x[0] + 6'd1;
    endcase
`else
    case (dir)
      UP:      ny = seg_y[0] - 5'd1;
      DOWN:    ny = seg_y[0] + 5'd1;
      LEFT:    nx = seg_x[0] - 6'd1;
      default: nx = seg_x[0] + 6'd1;
    endcase
    wall_hit = (nx == 6'd0) || (nx == 6'd39) || (ny == 5'd0) || (ny == 5'd29);
`endif
    eat  = (nx == cherry_x) && (ny == cherry_y);
    grow = eat && (len != 6'(MAX_LEN));
  end

  always_comb begin
    active     = '0;
    self_hit   = 1'b0;
`ifdef SNAKE_WRAP_EN
    cand_ok    = (cand_x <= 6'd39) && (cand_y <= 5'd29);
    wall_px    = 1'b0;
`else
    cand_ok    = (cand_x >= 6'd1) && (cand_x <= 6'd38) && (cand_y >= 5'd1) && (cand_y <= 5'd28);
    wall_px    = (cx == 6'd0) || (cx == 6'd39) || (cy == 6'd0) || (cy == 6'd29);
`endif
    snake_hit  = 1'b0;
    cherry_hit = (cherry_x == cx) && ({1'b0, cherry_y} == cy);
    for (int i = 0; i < MAX_LEN; i++) begin
      active[i] = (6'(i) < len);
      if (active[i] && seg_x[i] == cand_x && seg_y[i] == cand_y) cand_ok = 1'b0;
      if (active[i] && seg_x[i] == cx && {1'b0, seg_y[i]} == cy) snake_hit = 1'b1;
    end
    // The tail vacates its cell this tick unless the snake grows.
    for (int i = 1; i < MAX_LEN; i++) begin
      if (seg_x[i] == nx && seg_y[i] == ny &&
          ((6'(i + 1) < len) || (grow && 6'(i + 1) == len)))
        self_hit = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (any_btn) state_nxt = RUN;
      RUN: begin
        if (tick) begin
          if (wall_hit || self_hit) state_nxt = OVER;
          else if (eat)             state_nxt = RELOC;
        end
      end
      RELOC: if (cand_ok) state_nxt = RUN;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the segment file is reset because the initial snake must be drawn straight out of reset.
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < 3) ? 6'(20 - i) : 6'd0;
        seg_y[i] <= (i < 3) ? 5'd15 : 5'd0;
      end
      len      <= 6'd3;
      dir      <= RIGHT;
      cur_dir  <= RIGHT;
      cherry_x <= 6'd30;
      cherry_y <= 5'd15;
      score    <= 8'd0;
      tick_cnt <= '0;
      lfsr     <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      case (state)
        RUN: begin
          if (req_ok) dir <= req_dir;
          if (tick) begin
            tick_cnt <= '0;
            cur_dir  <= dir;
            if (!wall_hit && !self_hit) begin
              for (int i = MAX_LEN - 1; i > 0; i--) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
              end
              seg_x[0] <= nx;
              seg_y[0] <= ny;
              if (eat) begin
                if (grow) len <= len + 6'd1;
                if (score != 8'hFF) score <= score + 8'd1;
              end
            end
          end else begin
            tick_cnt <= tick_cnt + CW'(1);
          end
        end
        RELOC: begin
          if (cand_ok) begin
            cherry_x <= cand_x;
            cherry_y <= cand_y;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snake_on  <= 1'b0;
      cherry_on <= 1'b0;
      boundary  <= 1'b0;
    end else begin
      snake_on  <= in_range && snake_hit;
      cherry_on <= in_range && cherry_hit && (state != RELOC);
      boundary  <= in_range && wall_px;
    end
  end

endmodule

// File: tb/tb_snake_pixel_engine.sv
// Directed bench for snake_pixel_engine: pixel-query table, a full run into the cherry and
// the wall (or around the wrap when SNAKE_WRAP_EN is defined), and direction-latch sequences.
`timescale 1ns/1ps
module tb_snake_pixel_engine;

  localparam int TD = 4;
`ifdef SNAKE_WRAP_EN
  localparam logic NW = 1'b0;
`else
  localparam logic NW = 1'b1;
`endif

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic       s;
    logic       c;
    logic       b;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [9:0] pixel_x, pixel_y;
  logic       snake_on, cherry_on, boundary, game_over;
  logic [7:0] score;
  logic [15:0] lfsr_m;

  int checks = 0;
  int errors = 0;

  snake_pixel_engine #(.MAX_LEN(16), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .snake_on(snake_on), .cherry_on(cherry_on), .boundary(boundary),
    .game_over(game_over), .score(score)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR, free-running from reset like the one in the engine.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= lstep(lfsr_m);
  end

  function automatic bit cand_valid(input logic [15:0] l);
    int x, y;
    bit on_snake;
    x = int'(l[5:0]);
    y = int'(l[12:8]);
    on_snake = (y == 15) && (x >= 27) && (x <= 30);
`ifdef SNAKE_WRAP_EN
    return (x <= 39) && (y <= 29) && !on_snake;
`else
    return (x >= 1) && (x <= 38) && (y >= 1) && (y <= 28) && !on_snake;
`endif
  endfunction

  // Cherry chosen if the run starts at the next edge: eaten at edge 40, RELOC scans from there.
  task automatic predict(input logic [15:0] l0, output int px, output int py);
    logic [15:0] l;
    l = l0;
    for (int i = 0; i < 41; i++) l = lstep(l);
    for (int i = 0; i < 4000 && !cand_valid(l); i++) l = lstep(l);
    px = int'(l[5:0]);
    py = int'(l[12:8]);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic q(input int cx, input int cy);
    pixel_x = 10'(cx * 16 + 8);
    pixel_y = 10'(cy * 16 + 8);
  endtask

  task automatic wait_snake(input int cx, input int cy, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    q(cx, cy);
    for (int i = 0; i < budget && !seen; i++) begin
      cyc(1);
      seen = snake_on;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [13];
    int pcx, pcy;
    int sn, bd, ch, chx, chy;
    bit ch_snake;

    vecs[0]  = '{10'd320, 10'd240, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{10'd0,   10'd0,   1'b0, 1'b0, NW};
    vecs[2]  = '{10'd488, 10'd248, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{10'd639, 10'd479, 1'b0, 1'b0, NW};
    vecs[4]  = '{10'd640, 10'd240, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{10'd300, 10'd240, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{10'd319, 10'd255, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{10'd336, 10'd240, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{10'd16,  10'd16,  1'b0, 1'b0, 1'b0};
    vecs[9]  = '{10'd624, 10'd100, 1'b0, 1'b0, NW};
    vecs[10] = '{10'd100, 10'd464, 1'b0, 1'b0, NW};
    vecs[11] = '{10'd320, 10'd480, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{10'd287, 10'd240, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    pixel_x = 10'd320; pixel_y = 10'd240;
    cyc(2);
    check("rst_snake_on", 32'(snake_on), 32'd0);
    check("rst_cherry_on", 32'(cherry_on), 32'd0);
    check("rst_boundary", 32'(boundary), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      pixel_x = vecs[i].px;
      pixel_y = vecs[i].py;
      cyc(1);
      check($sformatf("vec%0d_snake", i), 32'(snake_on), 32'(vecs[i].s));
      check($sformatf("vec%0d_cherry", i), 32'(cherry_on), 32'(vecs[i].c));
      check($sformatf("vec%0d_boundary", i), 32'(boundary), 32'(vecs[i].b));
    end
    check("idle_score", 32'(score), 32'd0);

    // Start on a cycle whose relocated cherry stays off row 15, keeping the straight run clear.
    pcx = 0; pcy = 15;
    for (int i = 0; i < 64; i++) begin
      predict(lfsr_m, pcx, pcy);
      if (pcy != 15) break;
      cyc(1);
    end

    btn_right = 1'b1;
    cyc(1);
    btn_right = 1'b0;
    q(21, 15);
    cyc(4);
    check("first_move_not_early", 32'(snake_on), 32'd0);
    cyc(1);
    check("head_21", 32'(snake_on), 32'd1);
    q(18, 15);
    cyc(1);
    check("old_tail_gone", 32'(snake_on), 32'd0);
    q(19, 15);
    cyc(1);
    check("tail_19", 32'(snake_on), 32'd1);
    q(30, 15);
    cyc(32);
    check("cherry_before_eat", 32'(cherry_on), 32'd1);
    check("score_before_eat", 32'(score), 32'd0);
    cyc(1);
    check("score_after_eat", 32'(score), 32'd1);
    check("no_over_on_eat", 32'(game_over), 32'd0);
    cyc(1);
    check("cherry_hidden_reloc", 32'(cherry_on), 32'd0);

    wait_snake(31, 15, 40, "head_31");
    q(28, 15);
    cyc(1);
    check("len4_cell28", 32'(snake_on), 32'd1);
    q(27, 15);
    cyc(1);
    check("len4_cell27_free", 32'(snake_on), 32'd0);

    wait_snake(38, 15, 120, "head_38");
    cyc(2);
    check("no_over_before_tick", 32'(game_over), 32'd0);
    cyc(1);
`ifdef SNAKE_WRAP_EN
    check("wrap_no_over_39", 32'(game_over), 32'd0);
    wait_snake(0, 15, 40, "wrap_head_0");
    check("wrap_boundary_cx0", 32'(boundary), 32'd0);
    check("wrap_no_over_0", 32'(game_over), 32'd0);
`else
    check("over_after_wall", 32'(game_over), 32'd1);
    btn_up = 1'b1; btn_left = 1'b1;
    cyc(8);
    btn_up = 1'b0; btn_left = 1'b0;
    q(38, 15);
    cyc(1);
    check("frozen_head", 32'(snake_on), 32'd1);
    check("frozen_score", 32'(score), 32'd1);
    check("still_over", 32'(game_over), 32'd1);
`endif

    sn = 0; bd = 0; ch = 0; chx = -1; chy = -1; ch_snake = 1'b0;
    for (int cy = 0; cy < 30; cy++) begin
      for (int cx = 0; cx < 40; cx++) begin
        pixel_x = 10'(cx * 16 + 3);
        pixel_y = 10'(cy * 16 + 12);
        cyc(1);
        sn += int'(snake_on);
        bd += int'(boundary);
        if (cherry_on) begin
          ch++; chx = cx; chy = cy;
          if (snake_on) ch_snake = 1'b1;
        end
      end
    end
    check("scan_cherry_count", 32'(ch), 32'd1);
    check("scan_cherry_x", 32'(chx), 32'(pcx));
    check("scan_cherry_y", 32'(chy), 32'(pcy));
    check("scan_cherry_not_on_snake", 32'(ch_snake), 32'd0);
`ifdef SNAKE_WRAP_EN
    check("scan_boundary_count", 32'(bd), 32'd0);
`else
    check("scan_boundary_count", 32'(bd), 32'd136);
    check("scan_snake_count", 32'(sn), 32'd4);
`endif

    // Asynchronous reset, then the direction-latch sequences.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_score", 32'(score), 32'd0);
    check("async_rst_over", 32'(game_over), 32'd0);
    cyc(2);
    rst = 1'b0;

    btn_right = 1'b1;
    cyc(1);
    btn_right = 1'b0;
    btn_left = 1'b1;
    cyc(1);
    btn_left = 1'b0;
    q(21, 15);
    cyc(4);
    check("reverse_ignored", 32'(snake_on), 32'd1);
    check("reverse_no_over", 32'(game_over), 32'd0);
    btn_up = 1'b1;
    cyc(1);
    btn_up = 1'b0;
    btn_left = 1'b1;
    cyc(1);
    btn_left = 1'b0;
    q(21, 14);
    cyc(2);
    check("up_then_left_up", 32'(snake_on), 32'd1);
    btn_left = 1'b1;
    cyc(1);
    btn_left = 1'b0;
    btn_right = 1'b1;
    cyc(1);
    btn_right = 1'b0;
    q(22, 14);
    cyc(2);
    check("last_press_wins", 32'(snake_on), 32'd1);
    q(20, 14);
    cyc(1);
    check("left_not_applied", 32'(snake_on), 32'd0);
    btn_down = 1'b1; btn_left = 1'b1;
    cyc(1);
    btn_down = 1'b0; btn_left = 1'b0;
    q(22, 15);
    cyc(2);
    check("priority_down", 32'(snake_on), 32'd1);
    check("priority_no_over", 32'(game_over), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
